pulse_sequence_scheduler: RTL and testbench
===========================================

Name: pulse_sequence_scheduler

Overview:
- Sequences the pulse generator through a programmable table of up to DEPTH pulse configurations (delay, width, repetition), optionally looping the whole table.
- Sits between the HPS/PIO register interface and the pulse generator.
- For each entry it drives the generator's config buses, issues a one-cycle start, and waits for the generator's completion pulse before advancing.

Parameters:
- DEPTH, 8, number of table entries; power of two, ≥2.
- ADDR_W, $clog2(DEPTH), table index width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_wr_en  in  1  table write strobe.
- cfg_wr_addr  in  ADDR_W  table entry to write.
- cfg_wr_delay  in  32  entry delay_cycles.
- cfg_wr_width  in  32  entry pulse_width_cycles.
- cfg_wr_rep  in  16  entry repetition.
- seq_len  in  ADDR_W+1  number of entries to run, starting at entry 0; latched on go.
- loop_count  in  16  passes over the table; 0 = loop forever; latched on go.
- go  in  1  level input, rising-edge detected internally; starts a sequence.
- abort  in  1  level input; stops the sequence.
- gen_done  in  1  one-cycle pulse from the generator when its repetitions finish.
- gen_start  out  1  one-cycle start pulse to the generator.
- gen_stop  out  1  one-cycle pulse to the generator on abort.
- gen_delay_cycles  out  32  registered config to the generator.
- gen_pulse_width_cycles  out  32  registered config to the generator.
- gen_repetition  out  16  registered config to the generator.
- busy  out  1  high whenever state ≠ IDLE.
- seq_done  out  1  one-cycle pulse on normal completion.
- wr_err  out  1  one-cycle pulse when a write is rejected.
- cur_index  out  ADDR_W  entry currently loaded.

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - All outputs 0; all table entries 0.
  - Latched seq_len/loop values 0; go edge-detector register 0.
- Table writes:
  - Accepted in IDLE only; data is visible to a go issued on the following cycle.
  - cfg_wr_en while busy: write dropped, wr_err pulses the next cycle.
- go_edge = go & ~go_q, where go_q is registered every cycle in every state.
  - go_edge outside IDLE is ignored; it does not restart the sequence.
- seq_len latch: seq_len > DEPTH is clamped to DEPTH.
- FSM states: IDLE, LOAD, START, WAIT, NEXT. Each transition takes one clock edge.
- IDLE:
  - On go_edge with latched seq_len = 0: stay in IDLE and pulse seq_done the next cycle; no gen_start.
  - Otherwise: index = 0, loops_left = loop_count, go to LOAD.
- LOAD:
  - Register entry[index] onto the gen_* config buses; cur_index = index.
  - Config is stable for at least one cycle before gen_start.
  - If the entry's width = 0: go to NEXT with no start, since the generator would produce no pulse.
  - Otherwise go to START.
- START: gen_start = 1 for exactly one cycle, then go to WAIT.
- WAIT:
  - Hold until gen_done = 1, then go to NEXT.
  - An entry with rep = 0 runs forever; only abort or reset leaves WAIT.
- NEXT:
  - If index < seq_len−1: index+1, go to LOAD.
  - Else if loop_count = 0: index = 0, go to LOAD.
  - Else if loops_left > 1: loops_left−1, index = 0, go to LOAD.
  - Else: go to IDLE and pulse seq_done.
- Latency: go_edge at edge k → config valid after k+1 → gen_start high in cycle k+2 → first WAIT cycle at k+3.
- Between entries: gen_done at edge m → NEXT → LOAD → gen_start in cycle m+3.
- gen_done outside WAIT is ignored (stale completion).
- Simultaneous gen_done and abort: abort wins.
- abort (level, sampled every edge), from any non-IDLE state:
  - Next edge: state = IDLE, gen_stop pulses one cycle, busy = 0, no seq_done.
  - gen_* config buses hold their last values.
- abort in IDLE: no effect.
- Config buses change only in LOAD and are otherwise held.
- Arithmetic: index and loops_left are unsigned; loops_left never wraps below 1.

Test Plan:
- Write entries 0={3,2,1} and 1={2,1,2}; seq_len=2, loop_count=1; go rising → gen_start in cycle k+2 with config {3,2,1}; after gen_done, second gen_start 3 cycles later with {2,1,2}; after second gen_done, seq_done pulses once and busy falls.
- seq_len=3, loop_count=2, model generator with gen_done 5 cycles after each start → exactly 6 gen_start pulses; cur_index sequence 0,1,2,0,1,2; one seq_done.
- Entry 1 width=0, seq_len=3 → only 2 gen_start pulses (entries 0 and 2); entry 1 is skipped in 2 cycles.
- Entry 0={0,10,0}, loop_count=0, no gen_done → busy stays high for 500 cycles; assert abort → next cycle busy=0 and gen_stop=1 for one cycle; no seq_done.
- While busy: cfg_wr_en to entry 0 → wr_err pulses and the table is unchanged (verified by a subsequent go); go_edge while busy → no restart; seq_len=0 → seq_done with no gen_start.
- Assert reset mid-WAIT → all outputs 0 immediately (async), table cleared; after release, go with seq_len=1 issues gen_start with {0,0,0}? no — width 0 → skipped, seq_done only.

Source files
------------

// File: rtl/pulse_sequence_scheduler.sv
// pulse_sequence_scheduler: steps the pulse generator through a table of
// delay/width/repetition entries, optionally looping the table.
module pulse_sequence_scheduler #(
    parameter int DEPTH = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_wr_en,
    input  logic [ADDR_W-1:0] cfg_wr_addr,
    input  logic [31:0]       cfg_wr_delay,
    input  logic [31:0]       cfg_wr_width,
    input  logic [15:0]       cfg_wr_rep,
    input  logic [ADDR_W:0]   seq_len,
    input  logic [15:0]       loop_count,
    input  logic              go,
    input  logic              abort,
    input  logic              gen_done,
    output logic              gen_start,
    output logic              gen_stop,
    output logic [31:0]       gen_delay_cycles,
    output logic [31:0]       gen_pulse_width_cycles,
    output logic [15:0]       gen_repetition,
    output logic              busy,
    output logic              seq_done,
    output logic              wr_err,
    output logic [ADDR_W-1:0] cur_index
);
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, NEXT} state_t;
    localparam logic [ADDR_W:0] max_len = (ADDR_W+1)'(DEPTH);
    logic [31:0]       tbl_delay [DEPTH];
    logic [31:0]       tbl_width [DEPTH];
    logic [15:0]       tbl_rep   [DEPTH];
    state_t            state, state_n;
    logic              go_q, go_edge, active, more, again, done_n;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   len_q, len_in;
    logic [15:0]       loop_q, loops_left;
    assign go_edge   = go & ~go_q;
    assign active    = state != IDLE;
    assign len_in    = seq_len > max_len ? max_len : seq_len;
    assign more      = ({1'b0, idx} + (ADDR_W+1)'(1)) < len_q;
    assign again     = loop_q == '0 || loops_left > 16'd1;
    assign busy      = active;
    assign gen_start = state == START;
    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                state_n = go_edge && len_in != '0 ? LOAD : IDLE;
                done_n  = go_edge && len_in == '0;
            end
            LOAD:  state_n = tbl_width[idx] == '0 ? NEXT : START;
            START: state_n = WAIT;
            WAIT:  state_n = gen_done ? NEXT : WAIT;
            NEXT: begin
                state_n = more || again ? LOAD : IDLE;
                done_n  = !(more || again);
            end
            default: state_n = IDLE;
        endcase
        if (active && abort) begin
            state_n = IDLE;
            done_n  = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_delay[i] <= '0;
                tbl_width[i] <= '0;
                tbl_rep[i]   <= '0;
            end
            go_q                   <= 1'b0;
            gen_stop               <= 1'b0;
            seq_done               <= 1'b0;
            wr_err                 <= 1'b0;
            gen_delay_cycles       <= '0;
            gen_pulse_width_cycles <= '0;
            gen_repetition         <= '0;
            cur_index              <= '0;
            idx                    <= '0;
            len_q                  <= '0;
            loop_q                 <= '0;
            loops_left             <= '0;
        end else begin
            go_q     <= go;
            gen_stop <= active && abort;
            seq_done <= done_n;
            wr_err   <= cfg_wr_en && active;
            if (cfg_wr_en && !active) begin
                tbl_delay[cfg_wr_addr] <= cfg_wr_delay;
                tbl_width[cfg_wr_addr] <= cfg_wr_width;
                tbl_rep[cfg_wr_addr]   <= cfg_wr_rep;
            end
            if (!active && go_edge) begin
                len_q      <= len_in;
                loop_q     <= loop_count;
                loops_left <= loop_count;
                idx        <= '0;
            end
            // abort freezes the config buses and index where they are
            if (state == LOAD && !abort) begin
                gen_delay_cycles       <= tbl_delay[idx];
                gen_pulse_width_cycles <= tbl_width[idx];
                gen_repetition         <= tbl_rep[idx];
                cur_index              <= idx;
            end
            if (state == NEXT && !abort) begin
                if (more) idx <= idx + ADDR_W'(1);
                else begin
                    idx <= '0;
                    if (loop_q != '0 && loops_left > 16'd1) loops_left <= loops_left - 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pulse_sequence_scheduler.sv
// tb_pulse_sequence_scheduler: directed bench with a generator model and a
// queue of expected entry configs checked at every gen_start.
module tb_pulse_sequence_scheduler;
    logic        clk = 1'b0, reset = 1'b1;
    logic        cfg_wr_en = 1'b0;
    logic [2:0]  cfg_wr_addr = '0;
    logic [31:0] cfg_wr_delay = '0, cfg_wr_width = '0;
    logic [15:0] cfg_wr_rep = '0;
    logic [3:0]  seq_len = '0;
    logic [15:0] loop_count = '0;
    logic        go = 1'b0, abort = 1'b0, gen_done = 1'b0;
    logic        gen_start, gen_stop, busy, seq_done, wr_err;
    logic [31:0] gen_delay_cycles, gen_pulse_width_cycles;
    logic [15:0] gen_repetition;
    logic [2:0]  cur_index;
    int          errors = 0, checks = 0, cyc = 0, starts = 0, dones = 0, cd = 0, gen_lat = 4, g = 0;
    bit          gen_auto = 1'b0;
    logic [82:0] exp_q[$];
    int          start_cyc[$];

    pulse_sequence_scheduler #(.DEPTH(8)) dut (
        .clk(clk), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_delay(cfg_wr_delay), .cfg_wr_width(cfg_wr_width), .cfg_wr_rep(cfg_wr_rep),
        .seq_len(seq_len), .loop_count(loop_count), .go(go), .abort(abort),
        .gen_done(gen_done), .gen_start(gen_start), .gen_stop(gen_stop),
        .gen_delay_cycles(gen_delay_cycles), .gen_pulse_width_cycles(gen_pulse_width_cycles),
        .gen_repetition(gen_repetition), .busy(busy), .seq_done(seq_done),
        .wr_err(wr_err), .cur_index(cur_index)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [82:0] cfgv(input logic [31:0] d, input logic [31:0] w,
                                         input logic [15:0] r, input logic [2:0] i);
        return {d, w, r, i};
    endfunction

    // generator model: answers each start with gen_done gen_lat cycles later
    always @(negedge clk) begin
        gen_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) gen_done = 1'b1;
        end
        if (gen_start === 1'b1) begin
            starts++;
            start_cyc.push_back(cyc);
            chk("start_expected", 128'(exp_q.size() > 0), 128'(1));
            if (exp_q.size() > 0)
                chk("start_cfg", 128'({gen_delay_cycles, gen_pulse_width_cycles, gen_repetition, cur_index}),
                    128'(exp_q.pop_front()));
            if (gen_auto) cd = gen_lat;
        end
        if (seq_done === 1'b1) dones++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [31:0] w, input logic [15:0] r);
        cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_delay = d; cfg_wr_width = w; cfg_wr_rep = r;
        @(negedge clk);
        cfg_wr_en = 1'b0;
    endtask

    task automatic clear_counts();
        starts = 0; dones = 0; start_cyc.delete();
    endtask

    task automatic wait_done(input int bound, input string tag);
        int n = 0;
        while (seq_done !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 128'(seq_done), 128'(1));
    endtask

    function automatic int spacing();
        return start_cyc.size() >= 2 ? start_cyc[1] - start_cyc[0] : -1;
    endfunction

    initial begin
        @(negedge clk);
        chk("reset_outputs", 128'({busy, gen_start, gen_stop, seq_done, wr_err, cur_index,
            gen_delay_cycles, gen_pulse_width_cycles, gen_repetition}), 128'(0));
        reset = 1'b0;
        @(negedge clk);
        wr(3'd0, 32'd3, 32'd2, 16'd1);
        wr(3'd1, 32'd2, 32'd1, 16'd2);
        wr(3'd2, 32'd1, 32'd1, 16'd1);

        // two entries, one pass
        clear_counts();
        exp_q.push_back(cfgv(32'd3, 32'd2, 16'd1, 3'd0));
        exp_q.push_back(cfgv(32'd2, 32'd1, 16'd2, 3'd1));
        gen_auto = 1'b1; gen_lat = 4;
        seq_len = 4'd2; loop_count = 16'd1; go = 1'b1; g = cyc;
        wait_done(100, "t1_done");
        chk("t1_busy_low", 128'(busy), 128'(0));
        go = 1'b0;
        @(negedge clk);
        chk("t1_done_single", 128'(seq_done), 128'(0));
        chk("t1_starts", 128'(starts), 128'(2));
        chk("t1_go_latency", 128'(start_cyc.size() > 0 ? start_cyc[0] - g : -1), 128'(2));
        chk("t1_entry_gap", 128'(spacing()), 128'(gen_lat + 3));
        chk("t1_queue_empty", 128'(exp_q.size()), 128'(0));

        // three entries, two passes
        clear_counts();
        for (int p = 0; p < 2; p++) begin
            exp_q.push_back(cfgv(32'd3, 32'd2, 16'd1, 3'd0));
            exp_q.push_back(cfgv(32'd2, 32'd1, 16'd2, 3'd1));
            exp_q.push_back(cfgv(32'd1, 32'd1, 16'd1, 3'd2));
        end
        gen_lat = 5;
        seq_len = 4'd3; loop_count = 16'd2; go = 1'b1;
        wait_done(300, "t2_done");
        go = 1'b0;
        @(negedge clk);
        chk("t2_starts", 128'(starts), 128'(6));
        chk("t2_dones", 128'(dones), 128'(1));
        chk("t2_queue_empty", 128'(exp_q.size()), 128'(0));

        // zero-width entry is skipped
        wr(3'd1, 32'd5, 32'd0, 16'd7);
        clear_counts();
        exp_q.push_back(cfgv(32'd3, 32'd2, 16'd1, 3'd0));
        exp_q.push_back(cfgv(32'd1, 32'd1, 16'd1, 3'd2));
        gen_lat = 4;
        seq_len = 4'd3; loop_count = 16'd1; go = 1'b1;
        wait_done(200, "t3_done");
        go = 1'b0;
        @(negedge clk);
        chk("t3_starts", 128'(starts), 128'(2));
        chk("t3_skip_gap", 128'(spacing()), 128'(gen_lat + 5));
        chk("t3_queue_empty", 128'(exp_q.size()), 128'(0));

        // seq_len above DEPTH clamps to DEPTH
        clear_counts();
        exp_q.push_back(cfgv(32'd3, 32'd2, 16'd1, 3'd0));
        exp_q.push_back(cfgv(32'd1, 32'd1, 16'd1, 3'd2));
        seq_len = 4'd15; loop_count = 16'd1; go = 1'b1;
        wait_done(200, "clamp_done");
        go = 1'b0;
        @(negedge clk);
        chk("clamp_starts", 128'(starts), 128'(2));
        chk("clamp_last_index", 128'(cur_index), 128'(7));
        chk("clamp_queue_empty", 128'(exp_q.size()), 128'(0));

        // endless entry, busy-time writes and go, then abort
        wr(3'd0, 32'd0, 32'd10, 16'd0);
        clear_counts();
        exp_q.push_back(cfgv(32'd0, 32'd10, 16'd0, 3'd0));
        gen_auto = 1'b0;
        seq_len = 4'd1; loop_count = 16'd0; go = 1'b1;
        repeat (500) @(negedge clk);
        chk("t4_busy_held", 128'(busy), 128'(1));
        chk("t4_one_start", 128'(starts), 128'(1));
        wr(3'd0, 32'd9, 32'd9, 16'd9);
        chk("t4_wr_err", 128'(wr_err), 128'(1));
        @(negedge clk);
        chk("t4_wr_err_single", 128'(wr_err), 128'(0));
        go = 1'b0;
        @(negedge clk);
        go = 1'b1;
        repeat (5) @(negedge clk);
        chk("t4_go_ignored", 128'(starts), 128'(1));
        go = 1'b0; abort = 1'b1;
        @(negedge clk);
        chk("t4_abort_busy", 128'(busy), 128'(0));
        chk("t4_abort_stop", 128'(gen_stop), 128'(1));
        abort = 1'b0;
        @(negedge clk);
        chk("t4_stop_single", 128'(gen_stop), 128'(0));
        chk("t4_no_done", 128'(dones), 128'(0));
        chk("t4_cfg_held", 128'({gen_delay_cycles, gen_pulse_width_cycles, gen_repetition, cur_index}),
            128'(cfgv(32'd0, 32'd10, 16'd0, 3'd0)));

        // rejected write left entry 0 intact
        clear_counts();
        exp_q.push_back(cfgv(32'd0, 32'd10, 16'd0, 3'd0));
        gen_auto = 1'b1;
        loop_count = 16'd1; go = 1'b1;
        wait_done(100, "t5_done");
        go = 1'b0;
        @(negedge clk);
        chk("t5_starts", 128'(starts), 128'(1));
        chk("t5_queue_empty", 128'(exp_q.size()), 128'(0));

        // empty sequence
        clear_counts();
        seq_len = 4'd0; go = 1'b1;
        @(negedge clk);
        chk("len0_done", 128'(seq_done), 128'(1));
        chk("len0_busy", 128'(busy), 128'(0));
        go = 1'b0;
        @(negedge clk);
        chk("len0_done_single", 128'(seq_done), 128'(0));
        chk("len0_no_start", 128'(starts), 128'(0));

        // async reset during WAIT clears outputs and table
        clear_counts();
        exp_q.push_back(cfgv(32'd0, 32'd10, 16'd0, 3'd0));
        gen_auto = 1'b0;
        seq_len = 4'd1; go = 1'b1;
        repeat (6) @(negedge clk);
        chk("t6_busy", 128'(busy), 128'(1));
        go = 1'b0;
        #2 reset = 1'b1;
        #1 chk("t6_async_reset", 128'({busy, gen_start, gen_stop, seq_done, wr_err, cur_index,
            gen_delay_cycles, gen_pulse_width_cycles, gen_repetition}), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_counts();
        seq_len = 4'd3; loop_count = 16'd1; go = 1'b1;
        wait_done(50, "t6_done");
        go = 1'b0;
        @(negedge clk);
        chk("t6_table_cleared", 128'(starts), 128'(0));
        chk("final_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
